// File: rtl/rr_ring_arbiter.sv
// rr_ring_arbiter
//   Round-robin arbiter sharing one downstream resource among N requesters.
//   A one-hot ring pointer marks the highest-priority requester; it rotates
//   one position past the winner whenever a grant is released. A grant is
//   held while its owner keeps requesting, for up to QUANTUM cycles, after
//   which it is preempted if anyone else is waiting. Every release leaves
//   one all-zero grant cycle so the datapath select never switches directly
//   between two requesters.
//
// Optional feature (macro ARB_LOCK_EN):
//   adds input lock[N-1:0]; while lock[g] is high the granted requester g
//   cannot be preempted and the quantum counter saturates at QUANTUM.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req        in   [N-1:0] request vector
//   lock       in   [N-1:0] grant lock (ARB_LOCK_EN only)
//   gnt        out  [N-1:0] registered one-hot grant (zero when idle)
//   gnt_valid  out  registered, high when gnt is non-zero
//   gnt_id     out  binary index of the granted requester (held when idle)
//   ptr        out  [N-1:0] registered one-hot priority pointer
module rr_ring_arbiter #(
  parameter int N       = 4,
  parameter int QUANTUM = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
`ifdef ARB_LOCK_EN
  input  logic [N-1:0]  lock,
`endif
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_id,
  output logic [N-1:0]  ptr
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int QW = $clog2(QUANTUM + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  // One-hot vector with only bit idx set.
  function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) begin
      v[i] = (IW'(i) == idx);
    end
    return v;
  endfunction

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [IW-1:0]   gnt_id_q, gnt_id_d;
  logic [N-1:0]    ptr_q, ptr_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;

  logic [IW-1:0]   ptr_idx_s;
  logic [N-1:0]    req_rot_s;
  logic [IW-1:0]   win_s;
  logic [IW:0]     win_sum_s;
  logic            win_found_s;
  logic            lock_hold_s;

`ifdef ARB_LOCK_EN
  assign lock_hold_s = |(lock & gnt_q);
`else
  assign lock_hold_s = 1'b0;
`endif

  // Binary position of the priority pointer.
  always_comb begin
    ptr_idx_s = {IW{1'b0}};
    for (int i = 0; i < N; i++) begin
      ptr_idx_s = ptr_q[i] ? IW'(i) : ptr_idx_s;
    end
  end

  // Cyclic search for the first request at or above the pointer. The
  // request vector is rotated so bit 0 is the pointer position; the offset
  // of the first set bit is then added back modulo N.
  always_comb begin
    req_rot_s   = N'({req, req} >> ptr_idx_s);
    win_found_s = 1'b0;
    win_s       = {IW{1'b0}};
    win_sum_s   = {(IW+1){1'b0}};
    for (int i = 0; i < N; i++) begin
      if (!win_found_s && req_rot_s[i]) begin
        win_found_s = 1'b1;
        win_sum_s   = {1'b0, ptr_idx_s} + (IW+1)'(i);
        win_s       = (win_sum_s >= (IW+1)'(N)) ? IW'(win_sum_s - (IW+1)'(N))
                                                 : IW'(win_sum_s);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and next-output logic of the two-state arbiter.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    ptr_d       = ptr_q;
    qcnt_d      = qcnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = GRANT;
          gnt_d       = onehot(win_s);
          gnt_valid_d = 1'b1;
          gnt_id_d    = win_s;
          qcnt_d      = QW'(1);
        end else begin
          state_d     = IDLE;
        end
      end
      GRANT: begin
        // Release when the owner stops requesting, or when its quantum is
        // used up and someone else is waiting (unless locked). Both causes
        // together are still a single release with one pointer step.
        if (!(|(req & gnt_q)) ||
            ((qcnt_q == QW'(QUANTUM)) && (|(req & ~gnt_q)) && !lock_hold_s)) begin
          state_d     = IDLE;
          gnt_d       = {N{1'b0}};
          gnt_valid_d = 1'b0;
          qcnt_d      = {QW{1'b0}};
          ptr_d       = onehot((gnt_id_q == IW'(N - 1)) ? {IW{1'b0}}
                                                        : IW'(gnt_id_q + IW'(1)));
        end else if (qcnt_q == QW'(QUANTUM)) begin
          // Quantum renewal for a lone owner; a locked owner saturates.
          qcnt_d = lock_hold_s ? QW'(QUANTUM) : QW'(1);
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = {N{1'b0}};
        gnt_valid_d = 1'b0;
        qcnt_d      = {QW{1'b0}};
        ptr_d       = onehot({IW{1'b0}});
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= {N{1'b0}};
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= {IW{1'b0}};
      ptr_q       <= onehot({IW{1'b0}});
      qcnt_q      <= {QW{1'b0}};
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      ptr_q       <= ptr_d;
      qcnt_q      <= qcnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign ptr       = ptr_q;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Testbench for rr_ring_arbiter (N=4, QUANTUM=4): directed scenarios plus
// randomized request patterns, checked against an integer-level model of
// the arbitration rules.
module tb_rr_ring_arbiter;

  localparam int N = 4;
  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] lock_v;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic [3:0] ptr;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: granted index (-1 = none), grant-cycle count,
  // pointer index and last granted index.
  int m_g, m_q, m_p, m_id;

  int order_q[$];
  logic prev_valid;

  rr_ring_arbiter #(.N(N), .QUANTUM(Q)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
`ifdef ARB_LOCK_EN
    .lock      (lock_v),
`endif
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .ptr       (ptr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_g = -1; m_q = 0; m_p = 0; m_id = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] lk);
    int w;
    bit others;
    if (m_g < 0) begin
      if (r != 4'b0000) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          if (w < 0 && r[(m_p + k) % N]) w = (m_p + k) % N;
        end
        m_g = w; m_id = w; m_q = 1;
      end
    end else begin
      others = 1'b0;
      for (int k = 0; k < N; k++) if (k != m_g && r[k]) others = 1'b1;
      if (!r[m_g] || (m_q == Q && others && !lk[m_g])) begin
        m_p = (m_g + 1) % N;
        m_g = -1;
        m_q = 0;
      end else if (m_q == Q) begin
        m_q = lk[m_g] ? Q : 1;
      end else begin
        m_q = m_q + 1;
      end
    end
  endtask

  task automatic compare_all();
    check("gnt",       32'(gnt),       (m_g < 0) ? 32'd0 : (32'd1 << m_g));
    check("gnt_valid", 32'(gnt_valid), (m_g < 0) ? 32'd0 : 32'd1);
    check("gnt_id",    32'(gnt_id),    32'(m_id));
    check("ptr",       32'(ptr),       32'd1 << m_p);
  endtask

  // Drive req, let one rising edge pass, then compare away from the edge.
  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_step(r, lock_v);
    #1;
    compare_all();
    if (gnt_valid && !prev_valid) order_q.push_back(int'(gnt_id));
    prev_valid = gnt_valid;
  endtask

  // Pulse reset between edges and return just after the next falling edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_gnt",   32'(gnt),       32'd0);
    check("rst_valid", 32'(gnt_valid), 32'd0);
    check("rst_id",    32'(gnt_id),    32'd0);
    check("rst_ptr",   32'(ptr),       32'd1);
    @(negedge clk);
    rst = 1'b0;
    prev_valid = 1'b0;
  endtask

  initial begin
    int len;
    logic [3:0] r;
    // 1. Reset with the clock not yet having produced an edge.
    rst = 1'b1; req = 4'b0000; lock_v = 4'b0000; prev_valid = 1'b0;
    model_reset();
    #1;
    check("init_gnt",   32'(gnt),       32'd0);
    check("init_valid", 32'(gnt_valid), 32'd0);
    check("init_id",    32'(gnt_id),    32'd0);
    check("init_ptr",   32'(ptr),       32'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    step(4'b0000);
    step(4'b0000);

    // 2. Single request, one-cycle latency, drop after three cycles.
    step(4'b0100);
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_id",  32'(gnt_id), 32'd2);
    step(4'b0100);
    step(4'b0100);
    step(4'b0000);
    check("single_rel_gnt", 32'(gnt), 32'h0);
    check("single_rel_ptr", 32'(ptr), 32'h8);
    check("single_hold_id", 32'(gnt_id), 32'd2);

    // 3. Saturated fairness from a fresh pointer.
    do_reset();
    order_q.delete();
    for (int i = 0; i < 25; i++) step(4'b1111);
    check("fair_count", 32'(order_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("fair_order", (i < order_q.size()) ? 32'(order_q[i]) : 32'hFFFF, 32'(i % N));
    end

    // 4. Lone requester: continuous grant through quantum renewals.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(4'b0010);
      check("lone_gnt", 32'(gnt), 32'h2);
      check("lone_ptr", 32'(ptr), 32'h1);
    end
    step(4'b0000);

    // 5. Pointer wrap and skip.
    do_reset();
    step(4'b0100);
    step(4'b0000);
    check("wrap_ptr", 32'(ptr), 32'h8);
    step(4'b0101);
    check("wrap_gnt", 32'(gnt), 32'h1);
    for (int i = 0; i < 3; i++) step(4'b0101);
    step(4'b0101);
    check("wrap_rel_gnt", 32'(gnt), 32'h0);
    check("wrap_rel_ptr", 32'(ptr), 32'h2);
    step(4'b0101);
    check("wrap_next_gnt", 32'(gnt), 32'h4);

    // 6. Reset in the middle of that grant.
    do_reset();

`ifdef ARB_LOCK_EN
    lock_v = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step(4'b1001);
      check("lock_gnt", 32'(gnt), 32'h1);
    end
    lock_v = 4'b0000;
    step(4'b1001);
    check("lock_rel_gnt", 32'(gnt), 32'h0);
    step(4'b1001);
    check("lock_next_gnt", 32'(gnt), 32'h8);
    do_reset();
`endif

    // Randomized request patterns held for random durations.
    for (int s = 0; s < 120; s++) begin
      r   = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 7);
`ifdef ARB_LOCK_EN
      lock_v = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
`endif
      for (int c = 0; c < len; c++) step(r);
    end
    lock_v = 4'b0000;
    step(4'b0000);
    step(4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
